// File: rtl/regfile_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_mp_scoreboard
//   Multi-port integer register file with a per-register busy scoreboard for
//   the pipelined RISC-V core. Decode reads operands and issues destinations.
//   Write-back retires results. The hazard unit consumes the busy flags.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   rd_addr   NRD read addresses, port j at [j*AW +: AW]
//   rd_data   NRD read data (combinational), port j at [j*XLEN +: XLEN]
//   rd_busy   NRD busy flags of the addressed source registers
//   wr_en     NWR write enables (higher index = higher priority)
//   wr_addr   NWR write addresses
//   wr_data   NWR write data
//   iss_en    issue strobe: mark iss_addr busy
//   iss_addr  destination register of the issued instruction
//   busy_vec  full scoreboard, bit r = register r busy
// -----------------------------------------------------------------------------
module regfile_mp_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [NREG-1:0][XLEN-1:0] regs, regs_nxt;
  logic [NREG-1:0]           busy, busy_nxt;

  // Next state of the array and scoreboard. Ports are walked in ascending
  // order so the highest-index enabled port overrides lower ones.
  always_comb begin : next_state
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    regs_nxt = regs;
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) begin
        // NOTE: blocking assignments in combinational logic; later loop
        // iterations see and override earlier ones within the same evaluation.
        regs_nxt[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
        busy_nxt[wr_addr[i*AW +: AW]] = 1'b0;
      end
    end
    // Issue is applied after write-back so a same-edge issue keeps the
    // register busy: the new producer is still outstanding.
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    // Register 0 is hard-wired: writes and issues to it are simply dropped.
    regs_nxt[0] = '0;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the register array is reset here. The core relies on
  // architecturally zeroed registers after reset, so the storage must be
  // flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      regs <= regs_nxt;
      busy <= busy_nxt;
    end
  end

  // Combinational read ports with optional write-to-read forwarding.
  always_comb begin : read_ports
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_data[j*XLEN +: XLEN] = regs[rd_addr[j*AW +: AW]];
      rd_busy[j]              = busy[rd_addr[j*AW +: AW]];
      if (BYPASS != 0) begin
        // Forwarded value is the one about to be written, so the source is
        // no longer waiting on its producer.
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
            rd_data[j*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
            rd_busy[j]              = 1'b0;
          end
        end
      end
      // Address 0 and reset force zero; this also blocks forwarded data
      // from leaking out while reset is held.
      if (!rst || (rd_addr[j*AW +: AW] == '0)) begin
        rd_data[j*XLEN +: XLEN] = '0;
        rd_busy[j]              = 1'b0;
      end
    end
  end

  assign busy_vec = busy;

endmodule
